// File: rtl/pipe_add_stage.sv
// pipe_add_stage: STAGES-deep pipelined N-bit adder with valid/ready handshake.
// Each stage adds one W-bit chunk and passes its carry to the next stage.
// Optional signed-overflow output enabled by defining PIPE_ADD_OVF_EN.
module pipe_add_stage #(
  parameter int N      = 64,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W = N / STAGES;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] c_nxt;
  logic [STAGES-1:0] c_up;
  logic [STAGES-1:0] v_up;
  logic [N-1:0]      sum_r   [STAGES];
  logic [N-1:0]      a_r     [STAGES];
  logic [N-1:0]      b_r     [STAGES];
  logic [N-1:0]      sum_nxt [STAGES];
  logic [N-1:0]      a_up    [STAGES];
  logic [N-1:0]      b_up    [STAGES];
  logic [W:0]        tmp;

`ifdef PIPE_ADD_OVF_EN
  logic cmsb_r;
  logic cmsb_nxt;
`endif

  // Backpressure chain: a stage can load if it is empty or its successor can load.
  always_comb begin
    int unsigned k;
    rdy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      k = STAGES - 1 - i;
      if (k == STAGES - 1) rdy[k] = !v[k] | out_ready;
      else                 rdy[k] = !v[k] | rdy[k+1];
    end
  end

  // Per-stage chunk add on the upstream operands, carry and partial sums.
  always_comb begin
    v_up  = '0;
    c_up  = '0;
    c_nxt = '0;
    tmp   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum_nxt[k] = '0;
      a_up[k]    = '0;
      b_up[k]    = '0;
    end
    v_up[0] = in_valid;
    c_up[0] = cin;
    a_up[0] = a;
    b_up[0] = b;
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_up[k]    = v[k-1];
      c_up[k]    = c_r[k-1];
      a_up[k]    = a_r[k-1];
      b_up[k]    = b_r[k-1];
      sum_nxt[k] = sum_r[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      tmp = {1'b0, a_up[k][k*W +: W]} + {1'b0, b_up[k][k*W +: W]} + {{W{1'b0}}, c_up[k]};
      sum_nxt[k][k*W +: W] = tmp[W-1:0];
      c_nxt[k]             = tmp[W];
    end
  end

`ifdef PIPE_ADD_OVF_EN
  // Carry into the MSB recovered from the MSB operand bits and the MSB sum bit.
  always_comb begin
    cmsb_nxt = a_up[STAGES-1][N-1] ^ b_up[STAGES-1][N-1] ^ sum_nxt[STAGES-1][N-1];
  end
`endif

  // Stage registers: load on rdy, data only when the incoming beat is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      v   <= '0;
      c_r <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_r[k] <= '0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
      end
`ifdef PIPE_ADD_OVF_EN
      cmsb_r <= 1'b0;
`endif
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v[k] <= v_up[k];
          if (v_up[k]) begin
            sum_r[k] <= sum_nxt[k];
            c_r[k]   <= c_nxt[k];
            a_r[k]   <= a_up[k];
            b_r[k]   <= b_up[k];
          end
        end
      end
`ifdef PIPE_ADD_OVF_EN
      if (rdy[STAGES-1] && v_up[STAGES-1]) cmsb_r <= cmsb_nxt;
`endif
    end
  end

  assign in_ready  = rdy[0] & !reset;
  assign out_valid = v[STAGES-1];
  assign sum       = sum_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
`ifdef PIPE_ADD_OVF_EN
  assign ovf       = cmsb_r ^ c_r[STAGES-1];
`endif

endmodule
